// File: rtl/vga_capture.sv
// 1 bpp video receiver: decodes sync/de, deserialises pixels MSB-first
// and writes captured bytes using the graphics-mode row/byte layout.
module vga_capture #(
    parameter int PIX_DIV  = 2,
    parameter int LINE_DIV = 4,
    parameter int H_ACTIVE = 512,
    parameter int V_ACTIVE = 768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic        pixel_in,
    output logic [12:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        frame_done,
    output logic        locked,
    output logic        err,
    output logic [9:0]  line_period
);

    localparam int PCW = $clog2(H_ACTIVE + 2) + 1;
    localparam int LCW = $clog2(V_ACTIVE + 2) + 1;
    localparam logic [PCW-1:0] H_LEN   = PCW'(H_ACTIVE);
    localparam logic [PCW-1:0] PX_MASK = PCW'(PIX_DIV - 1);
    localparam logic [LCW-1:0] V_LEN   = LCW'(V_ACTIVE);

    typedef enum logic [1:0] {SEEK_VS, IN_VS, FRAME} state_t;

    state_t state_q, state_d;

    logic hs_r, vs_r, de_r, px_r;
    logic hs_q, vs_q, de_q;
    logic vs_fall, vs_rise, de_rise, de_fall, hs_fall;

    logic [PCW-1:0] pc, pc_cur;
    logic [LCW-1:0] line_cnt;
    logic [2:0]     bit_cnt, bit_cur;
    logic [4:0]     byte_idx, byte_cur;
    logic [7:0]     sh, sh_cur, row;
    logic           line_we, err_flag;
    logic [9:0]     hc;
    logic           hp_valid;

    logic in_frame, sample, byte_done;
    logic frame_end, len_err, vsde_err, cnt_err, any_err;

    assign vs_fall = vs_q & ~vs_r;
    assign vs_rise = ~vs_q & vs_r;
    assign de_rise = de_r & ~de_q;
    assign de_fall = ~de_r & de_q;
    assign hs_fall = hs_q & ~hs_r;

    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        len_err   = 1'b0;
        vsde_err  = 1'b0;
        cnt_err   = 1'b0;
        unique case (state_q)
            SEEK_VS: begin
                if (vs_fall) state_d = IN_VS;
            end
            IN_VS: begin
                vsde_err = de_rise;
                if (vs_rise) state_d = FRAME;
            end
            FRAME: begin
                len_err = de_fall && (pc != H_LEN);
                cnt_err = de_rise && (line_cnt == V_LEN);
                if (vs_fall) begin
                    frame_end = 1'b1;
                    state_d   = IN_VS;
                    if (line_cnt != V_LEN) cnt_err = 1'b1;
                end
            end
            default: state_d = SEEK_VS;
        endcase
        any_err = len_err | vsde_err | cnt_err;
    end

    // A new line restarts the pixel, bit and byte counters in its first cycle
    always_comb begin
        in_frame  = (state_q == FRAME);
        pc_cur    = de_rise ? '0 : pc;
        bit_cur   = de_rise ? '0 : bit_cnt;
        byte_cur  = de_rise ? '0 : byte_idx;
        sh_cur    = {sh[6:0], px_r};
        sample    = in_frame && de_r && ((pc_cur & PX_MASK) == PX_MASK);
        byte_done = sample && (bit_cur == 3'd7);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            de_r        <= 1'b0;
            px_r        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            state_q     <= SEEK_VS;
            pc          <= '0;
            line_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            sh          <= '0;
            row         <= '0;
            line_we     <= 1'b0;
            err_flag    <= 1'b0;
            hc          <= '0;
            hp_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_en       <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            line_period <= '0;
        end else begin
            hs_r <= hsync_in;
            vs_r <= vsync_in;
            de_r <= de_in;
            px_r <= pixel_in;
            hs_q <= hs_r;
            vs_q <= vs_r;
            de_q <= de_r;

            state_q    <= state_d;
            wr_en      <= 1'b0;
            err        <= any_err;
            frame_done <= frame_end;

            if (any_err)
                locked <= 1'b0;
            else if (frame_end && !err_flag)
                locked <= 1'b1;

            if (state_d == IN_VS && state_q != IN_VS)
                err_flag <= 1'b0;
            else if (any_err)
                err_flag <= 1'b1;

            if (!in_frame) begin
                pc       <= '0;
                line_cnt <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
                row      <= '0;
                line_we  <= 1'b0;
            end else begin
                // Lines past V_ACTIVE are never written
                if (de_rise) begin
                    if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
                    line_we <= (int'(line_cnt) % LINE_DIV == 0)
                               && (line_cnt < V_LEN);
                    row     <= 8'(int'(line_cnt) / LINE_DIV);
                end
                if (de_r)
                    pc <= (pc_cur != '1) ? pc_cur + 1'b1 : pc_cur;
                bit_cnt  <= sample ? bit_cur + 1'b1 : bit_cur;
                byte_idx <= byte_done ? byte_cur + 1'b1 : byte_cur;
                if (sample) sh <= sh_cur;
                if (byte_done) begin
                    wr_en   <= line_we;
                    wr_data <= sh_cur;
                    wr_addr <= {row, byte_cur};
                end
            end

            // Period only trusted when both bounding edges fall outside vsync
            if (hs_fall)
                hc <= 10'd1;
            else if (hc != '1)
                hc <= hc + 10'd1;
            if (!vs_r) begin
                hp_valid <= 1'b0;
            end else if (hs_fall) begin
                hp_valid <= 1'b1;
                if (hp_valid) line_period <= hc;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: reduced frame geometry, scoreboarded writes,
// table of frame scenarios plus reset and latency sequences.
module tb_vga_capture;

    localparam int PD = 2;
    localparam int LD = 4;
    localparam int HA = 128;
    localparam int VA = 16;
    localparam int LT = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync, de, px;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en, frame_done, locked, err;
    logic [9:0]  line_period;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int wr_cnt = 0;
    int push_cnt = 0;

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int nl;
        int bl;
        int blen;
        bit dv;
        int xerr;
        bit xlock;
    } vec_t;
    vec_t tbl[10];

    vga_capture #(
        .PIX_DIV(PD), .LINE_DIV(LD), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .reset(reset),
        .hsync_in(hsync), .vsync_in(vsync),
        .de_in(de), .pixel_in(px),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .frame_done(frame_done), .locked(locked), .err(err),
        .line_period(line_period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int l, input int b,
                                       input logic [7:0] key);
        logic [12:0] a;
        a = {8'(l / LD), 5'(b)};
        return a[7:0] ^ key ^ 8'((l % LD) * 51);
    endfunction

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (wr_en) begin
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr %0h data %0h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.a);
                chk("wr_data", wr_data, e.d);
            end
        end
    end

    task automatic drive_line(input int l, input int len,
                              input logic [7:0] key, input bit cap);
        logic [7:0] d;
        if (cap && l < VA && l % LD == 0)
            for (int b = 0; b < len / (8 * PD); b++) begin
                exp_q.push_back({13'({8'(l / LD), 5'(b)}), pat(l, b, key)});
                push_cnt++;
            end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); hsync = 1'b0; de = 1'b0; px = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); hsync = 1'b1;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            d  = pat(l, i / (8 * PD), key);
            de = 1'b1;
            px = d[7 - (i / PD) % 8];
            if (cap && l == 0 && i == 16) chk("wr_lat_early", wr_en, 0);
            if (cap && l == 0 && i == 17) begin
                chk("wr_lat", wr_en, 1);
                chk("wr_first_addr", wr_addr, 0);
            end
        end
        for (int j = 0; j < LT - 16 - len; j++) begin
            @(negedge clk); de = 1'b0; px = 1'b0;
            if (cap && len != HA && j == 1) chk("len_err_early", err, 0);
            if (cap && len != HA && j == 2) chk("len_err", err, 1);
        end
    endtask

    task automatic vs_block(input bit dp, input bit xfd, input bit xlk,
                            output logic lk);
        for (int j = 0; j < 2 * LT; j++) begin
            @(negedge clk);
            vsync = 1'b0; hsync = 1'b0; px = 1'b0;
            de = dp && j >= 100 && j < 110;
            if (j == 1) chk("fd_early", frame_done, 0);
            if (j == 2) begin
                chk("frame_done", frame_done, xfd);
                if (xfd) chk("locked_fe", locked, xlk);
            end
            if (j == 3) chk("fd_width", frame_done, 0);
            if (j == 102) chk("vs_de_err", err, dp);
        end
        lk = locked;
        vsync = 1'b1;
    endtask

    initial begin
        logic       lk;
        logic [7:0] key;
        int         e0, w0, p0, len;

        tbl[0] = '{16, -1, 128, 0, 0, 1};
        tbl[1] = '{16,  4, 126, 0, 1, 0};
        tbl[2] = '{16, -1, 128, 0, 0, 1};
        tbl[3] = '{15, -1, 128, 0, 1, 0};
        tbl[4] = '{17, -1, 128, 0, 2, 0};
        tbl[5] = '{16, -1, 128, 1, 1, 1};
        tbl[6] = '{16, -1, 128, 0, 0, 0};
        tbl[7] = '{16, -1, 128, 0, 0, 1};
        tbl[8] = '{16,  8, 130, 0, 1, 0};
        tbl[9] = '{16, -1, 128, 0, 0, 1};

        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0; px = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_line_period", line_period, 0);
        @(negedge clk); reset = 1'b0;

        vs_block(0, 0, 0, lk);
        for (int l = 0; l < 5; l++) drive_line(l, HA, 8'hC3, 1);
        repeat (8) begin @(negedge clk); hsync = 1'b0; end
        repeat (8) begin @(negedge clk); hsync = 1'b1; end
        repeat (40) begin @(negedge clk); de = 1'b1; px = 1'($urandom); end
        chk("pre_rst_period", line_period, LT);
        @(negedge clk); reset = 1'b1; de = 1'b0; px = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_period", line_period, 0);
        @(negedge clk); reset = 1'b0;
        chk("pre_rst_writes", wr_cnt, push_cnt);
        e0 = err_cnt; w0 = wr_cnt;
        for (int l = 6; l < VA; l++) drive_line(l, HA, 8'hC3, 0);
        vs_block(0, 0, 0, lk);
        chk("seek_writes", wr_cnt - w0, 0);
        chk("seek_errs", err_cnt - e0, 0);
        chk("seek_locked", lk, 0);

        for (int k = 0; k < 10; k++) begin
            key = (k == 0) ? 8'h5A : 8'($urandom);
            e0 = err_cnt; w0 = wr_cnt; p0 = push_cnt;
            for (int l = 0; l < tbl[k].nl; l++) begin
                len = (l == tbl[k].bl) ? tbl[k].blen : HA;
                drive_line(l, len, key, 1);
            end
            vs_block(tbl[k].dv, 1, tbl[k].xlock, lk);
            chk("err_count", err_cnt - e0, tbl[k].xerr);
            chk("write_count", wr_cnt - w0, push_cnt - p0);
            chk("queue_drained", exp_q.size(), 0);
            chk("locked_end", lk, tbl[k].xlock & ~tbl[k].dv);
            chk("line_period", line_period, LT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Sync-and-pixel receiver for the 1 bpp video output stream. Sits on the far end of the video output port, in loopback benches and the frame-grab path. Decodes sync and data-enable, deserialises the pixel line into bytes, and writes them through a byte write port. The write addresses use the same row/byte layout that the output side fetches in graphics mode, so a captured frame can be compared byte-for-byte against video memory.

## Interface
Parameters:
- `PIX_DIV`, 2: clocks per source pixel (power of 2).
- `LINE_DIV`, 4: scan lines per memory row. Only the first line of each group is written.
- `H_ACTIVE`, 512: expected clocks of `de_in` high per line.
- `V_ACTIVE`, 768: expected active lines per frame.

Ports (all in the `clk` domain; inputs come from the same clock):
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `hsync_in` in 1: composite horizontal sync, active low (also low during vsync).
- `vsync_in` in 1: vertical sync, active low.
- `de_in` in 1: active-video enable. Aligned with `pixel_in`.
- `pixel_in` in 1: pixel value. MSB of each byte arrives first.
- `wr_addr` out 13: {row[7:0], byte[4:0]}.
- `wr_data` out 8: captured byte.
- `wr_en` out 1: one-cycle write strobe.
- `frame_done` out 1: one-cycle pulse at the end of each captured frame.
- `locked` out 1: the last frame completed without error.
- `err` out 1: one-cycle pulse on any timing violation.
- `line_period` out 10: clocks between hsync falling edges, saturating at 1023.

## Operation
- All inputs pass through one register stage. Edge detection is done on the registered copies.
- State machine:
  - SEEK_VS (entered at reset): wait for a vsync falling edge, then go to IN_VS.
  - IN_VS: hold line, row and byte counters at 0. On vsync rising edge, go to FRAME.
  - FRAME: capture. On vsync falling edge:
    - pulse `frame_done`;
    - check line count == `V_ACTIVE`;
    - go to IN_VS.
- Line count: incremented on each `de` rising edge in FRAME.
  - Write enable for the line is `line % LINE_DIV == 0`.
  - `row = line / LINE_DIV`, truncated to 8 bits.
- Within a line:
  - Clock counter `pc` runs from 0 while de is high.
  - A sample is taken when `pc % PIX_DIV == PIX_DIV-1` and shifted in MSB-first.
  - After 8 samples the byte is presented and `wr_en` pulses if the line is write-enabled.
  - The byte index increments mod 32 and clears at de rising edge.
- Error conditions. Each gives one `err` pulse and sets a per-frame error flag:
  - de falling edge with `pc` != `H_ACTIVE`;
  - de high in IN_VS;
  - line count reaching `V_ACTIVE` + 1. Further writes are suppressed until the next vsync.
  - Two conditions in the same cycle give a single pulse.
- `locked`:
  - set at a frame end whose error flag is clear;
  - cleared on any `err` pulse;
  - the error flag clears on entry to IN_VS.
- Partial byte at de falling edge (`H_ACTIVE` not a multiple of `8*PIX_DIV`) is discarded.
- `line_period`:
  - counts clocks between registered hsync falling edges, updated only while vsync is high;
  - holds its last value in vsync.

## Timing
- Reset value of every output is 0. State returns to SEEK_VS immediately on reset, including mid-frame and mid-byte; the partial byte is lost.
- Latency: if the last input clock of a byte's 8th pixel is at the ports in cycle t, `wr_en`, `wr_addr` and `wr_data` are valid in cycle t+2, for exactly one cycle.
- Bytes of one line are written `8*PIX_DIV` clocks apart (16 by default).
- `frame_done` and the frame-end `locked` update occur at t+2 relative to the vsync falling edge at the ports.
- `err` occurs at t+2 relative to the offending input edge.
- Simultaneous vsync fall and de fall: the line-length check is evaluated first, then the frame check. Both feed the same frame's error flag.
- No writes occur in SEEK_VS or IN_VS. The first write after reset is at row 0, byte 0.

## Test plan
- **Reset mid-line:** assert `reset` for 3 clocks during active video → all outputs 0; no `wr_en` until one full vsync low→high has passed.
- **Clean frame:** 672-clock lines, 512 de clocks, 768 lines, byte at addr A = A[7:0] XOR 8'h5A, 2 clocks/pixel → exactly 6144 writes with matching data. Then `frame_done`=1 for one cycle, `locked`=1, `err` never asserted, `line_period`=672.
- **Short line:** line 100 with 510 de clocks → one `err` pulse 2 cycles after the de fall; `locked`=0; next clean frame sets `locked`=1.
- **Line count:** frame with 767 lines → `frame_done` pulse, `err` pulse, `locked`=0. Frame with 769 lines → `err` on line 769 and no writes from line 769.
- **de during vsync:** de pulse while vsync is low → `err` pulse; no `wr_en`.
- **Row decimation:** lines 0–3 carry different patterns → only line 0's bytes are written to row 0; addresses 0x0000–0x001F.
